// File: rtl/uart_reg_responder.sv
// Purpose: turns a UART byte stream into register reads/writes and returns one response byte per frame.
// Latency: NAK 1 cycle after the opcode, ACK 2 cycles after the data byte, read data 3 cycles after the address byte.
// Backpressure: rx_data_ready is low while a frame executes or a response waits; tx_data is held until tx_data_ready.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   rx_data/_valid/_ready       byte input from the UART receiver (valid/ready)
//   tx_data/_valid/_ready       response byte to the UART transmitter (valid/ready)
//   reg_addr, reg_wdata         register bus address and write data (held between frames)
//   reg_we, reg_re              one-cycle write / read strobes (mutually exclusive)
//   reg_rdata                   read data, valid the cycle after reg_re
//   frame_abort                 one-cycle pulse when a partial frame is dropped on inter-byte timeout
//
// Frames: 'W' addr data -> ACK_BYTE ; 'R' addr -> register value ; any other opcode -> NAK_BYTE.

module uart_reg_responder #(
    parameter int          TIMEOUT  = 50000,
    parameter logic [7:0]  ACK_BYTE = 8'h4B,
    parameter logic [7:0]  NAK_BYTE = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,

    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       rx_data_ready,

    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_data_ready,

    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,

    output logic       frame_abort
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    // Last counter value before the frame is dropped: a frame may sit
    // TIMEOUT cycles in a byte-wait state without a transfer.
    localparam logic [23:0] CNT_LAST = 24'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  addr_q,  addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  txd_q,   txd_d;
    logic [23:0] cnt_q,   cnt_d;

    logic        rx_xfer;
    logic        byte_wait;
    logic        timeout_hit;
    logic        abort;

    // Ready is a pure state decode, so bytes arriving mid-frame stay
    // pending in the receiver instead of being dropped.
    assign rx_data_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign rx_xfer       = rx_data_valid && rx_data_ready;

    // Only the two mid-frame byte-wait states are subject to the timeout;
    // a transfer in the same cycle takes priority over the abort.
    assign byte_wait   = (state_q == S_ADDR) || (state_q == S_WDATA);
    assign timeout_hit = byte_wait && !rx_xfer && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_xfer) begin
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        is_wr_d = (rx_data == OP_WRITE);
                        cnt_d   = 24'd0;
                        state_d = S_ADDR;
                    end else begin
                        txd_d   = NAK_BYTE;
                        state_d = S_RESP;
                    end
                end
            end

            S_ADDR: begin
                if (rx_xfer) begin
                    addr_d = rx_data;
                    if (is_wr_q) begin
                        cnt_d   = 24'd0;
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_READ;
                    end
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            S_WDATA: begin
                if (rx_xfer) begin
                    wdata_d = rx_data;
                    state_d = S_WRITE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            S_WRITE: begin
                txd_d   = ACK_BYTE;
                state_d = S_RESP;
            end

            S_READ: begin
                state_d = S_RWAIT;
            end

            // reg_rdata is valid now, one cycle after the read strobe.
            S_RWAIT: begin
                txd_d   = reg_rdata;
                state_d = S_RESP;
            end

            S_RESP: begin
                if (tx_data_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            txd_q   <= 8'h00;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_data       = txd_q;
    assign tx_data_valid = (state_q == S_RESP);
    assign reg_addr      = addr_q;
    assign reg_wdata     = wdata_q;
    assign reg_we        = (state_q == S_WRITE);
    assign reg_re        = (state_q == S_READ);
    assign frame_abort   = abort;

endmodule
